// File: rtl/ceespu_ex_stage_if.sv
// Execute-stage bus: decode/ALU-facing inputs and EX/MEM-facing outputs of
// the ceespu execute-stage controller.
interface ceespu_ex_stage_if #(
  parameter int RD_W = 5
);
  logic            I_valid;
  logic [RD_W-1:0] I_rd;
  logic            I_we;
  logic            I_setCarry;
  logic            I_useCarry;
  logic            I_flush;
  logic            I_memStall;
  logic [31:0]     I_aluResult;
  logic            I_aluCout;
  logic            I_aluMultiCycle;
  logic            I_aluDataReady;
  logic            O_Cin;
  logic            O_stall;
  logic            O_valid;
  logic [31:0]     O_result;
  logic [RD_W-1:0] O_rd;
  logic            O_we;
  logic            O_carry;
  logic            O_mulTimeout;

  // Decode/ALU side: drives the instruction and ALU results, observes EX outputs
  modport master (
    output I_valid, I_rd, I_we, I_setCarry, I_useCarry, I_flush, I_memStall,
           I_aluResult, I_aluCout, I_aluMultiCycle, I_aluDataReady,
    input  O_Cin, O_stall, O_valid, O_result, O_rd, O_we, O_carry, O_mulTimeout
  );

  // Execute stage itself
  modport slave (
    input  I_valid, I_rd, I_we, I_setCarry, I_useCarry, I_flush, I_memStall,
           I_aluResult, I_aluCout, I_aluMultiCycle, I_aluDataReady,
    output O_Cin, O_stall, O_valid, O_result, O_rd, O_we, O_carry, O_mulTimeout
  );
endinterface

// File: rtl/ceespu_ex_stage.sv
// ceespu execute-stage controller: retires ALU results into the EX/MEM
// register, sequences multi-cycle multiplies with a stall FSM, and owns the
// architectural carry flag fed back into the ALU.
module ceespu_ex_stage #(
  parameter int RD_W        = 5,
  parameter int MUL_TIMEOUT = 7
) (
  input  logic              I_clk,
  input  logic              I_rst,
  ceespu_ex_stage_if.slave  bus
);

  localparam int CNT_W = $clog2(MUL_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    MUL_HOLD = 2'd2
  } state_t;

  state_t          r_state;
  logic [CNT_W-1:0] r_waitCnt;
  logic [31:0]     r_hold;
  logic            r_valid;
  logic [31:0]     r_result;
  logic [RD_W-1:0] r_rd;
  logic            r_we;
  logic            r_carry;
  logic            r_mulTimeout;
  logic            w_stall;

  // Hold decode/EX operands while a multiply is outstanding or memory backs up
  always_comb begin
    w_stall = bus.I_memStall;
    case (r_state)
      RUN:      if (bus.I_valid && bus.I_aluMultiCycle && !bus.I_flush) w_stall = 1'b1;
      MUL_WAIT: w_stall = 1'b1;
      MUL_HOLD: if (bus.I_memStall) w_stall = 1'b1;
      default:  w_stall = bus.I_memStall;
    endcase
  end

  assign bus.O_stall      = w_stall;
  assign bus.O_Cin        = bus.I_useCarry & r_carry;
  assign bus.O_valid      = r_valid;
  assign bus.O_result     = r_result;
  assign bus.O_rd         = r_rd;
  assign bus.O_we         = r_we;
  assign bus.O_carry      = r_carry;
  assign bus.O_mulTimeout = r_mulTimeout;

  // Stall FSM, EX/MEM register, carry flag and multiply watchdog
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state      <= RUN;
      r_waitCnt    <= '0;
      r_hold       <= '0;
      r_valid      <= 1'b0;
      r_result     <= '0;
      r_rd         <= '0;
      r_we         <= 1'b0;
      r_carry      <= 1'b0;
      r_mulTimeout <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          // A flush under memStall is ignored: the killed op is still upstream
          if (!bus.I_memStall) begin
            if (bus.I_flush) begin
              r_valid <= 1'b0;
              r_we    <= 1'b0;
            end else if (bus.I_valid && bus.I_aluMultiCycle) begin
              r_state   <= MUL_WAIT;
              r_waitCnt <= '0;
              r_valid   <= 1'b0;
              r_we      <= 1'b0;
            end else if (bus.I_valid) begin
              r_valid  <= 1'b1;
              r_result <= bus.I_aluResult;
              r_rd     <= bus.I_rd;
              r_we     <= bus.I_we;
              if (bus.I_setCarry) r_carry <= bus.I_aluCout;
            end else begin
              r_valid <= 1'b0;
              r_we    <= 1'b0;
            end
          end
        end
        MUL_WAIT: begin
          // Saturating wait counter; the timeout flag is sticky until reset
          if (r_waitCnt != CNT_W'(MUL_TIMEOUT)) r_waitCnt <= r_waitCnt + 1'b1;
          if (r_waitCnt == CNT_W'(MUL_TIMEOUT - 1)) r_mulTimeout <= 1'b1;
          if (bus.I_flush) begin
            r_state <= RUN;
            if (!bus.I_memStall) begin
              r_valid <= 1'b0;
              r_we    <= 1'b0;
            end
          end else if (bus.I_aluDataReady) begin
            r_hold <= bus.I_aluResult;
            if (!bus.I_memStall) begin
              r_state  <= RUN;
              r_valid  <= 1'b1;
              r_result <= bus.I_aluResult;
              r_rd     <= bus.I_rd;
              r_we     <= bus.I_we;
            end else begin
              r_state <= MUL_HOLD;
            end
          end else if (!bus.I_memStall) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
          end
        end
        MUL_HOLD: begin
          if (bus.I_flush) begin
            r_state <= RUN;
            if (!bus.I_memStall) begin
              r_valid <= 1'b0;
              r_we    <= 1'b0;
            end
          end else if (!bus.I_memStall) begin
            r_state  <= RUN;
            r_valid  <= 1'b1;
            r_result <= r_hold;
            r_rd     <= bus.I_rd;
            r_we     <= bus.I_we;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ceespu_ex_stage.sv
// Self-checking bench for ceespu_ex_stage: directed scenarios with literal
// expectations, then randomized inputs checked every cycle against a
// transaction-level model of the execute stage.
module tb_ceespu_ex_stage;

  localparam int RD_W = 5;
  localparam int TMO  = 7;

  logic clk;
  logic rst;

  ceespu_ex_stage_if #(.RD_W(RD_W)) bus ();

  ceespu_ex_stage #(.RD_W(RD_W), .MUL_TIMEOUT(TMO)) dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: is a multiply waiting for its product, or is a product parked?
  bit              m_known;
  bit              m_busy;
  bit              m_have;
  logic [31:0]     m_product;
  int              m_waited;
  bit              m_valid;
  bit              m_we;
  logic [31:0]     m_result;
  logic [RD_W-1:0] m_rd;
  bit              m_carry;
  bit              m_tmo;
  logic            last_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.I_valid = 0; bus.I_rd = '0; bus.I_we = 0; bus.I_setCarry = 0;
    bus.I_useCarry = 0; bus.I_flush = 0; bus.I_memStall = 0;
    bus.I_aluResult = '0; bus.I_aluCout = 0; bus.I_aluMultiCycle = 0;
    bus.I_aluDataReady = 0;
  endtask

  // Retire a value into the model's EX/MEM register
  task automatic m_retire(input logic [31:0] val);
    m_valid  = 1; m_result = val; m_rd = bus.I_rd; m_we = bus.I_we;
  endtask

  task automatic m_bubble();
    m_valid = 0; m_we = 0;
  endtask

  // Advance the model by one clock edge using the inputs presented this cycle
  task automatic m_update();
    if (rst) begin
      m_known = 1; m_busy = 0; m_have = 0; m_product = '0; m_waited = 0;
      m_valid = 0; m_we = 0; m_result = '0; m_rd = '0; m_carry = 0; m_tmo = 0;
    end else if (m_busy) begin
      m_waited++;
      if (m_waited >= TMO) m_tmo = 1;
      if (bus.I_flush) begin
        m_busy = 0;
        if (!bus.I_memStall) m_bubble();
      end else if (bus.I_aluDataReady) begin
        m_busy = 0;
        m_product = bus.I_aluResult;
        if (!bus.I_memStall) m_retire(m_product);
        else m_have = 1;
      end else if (!bus.I_memStall) m_bubble();
    end else if (m_have) begin
      if (bus.I_flush) begin
        m_have = 0;
        if (!bus.I_memStall) m_bubble();
      end else if (!bus.I_memStall) begin
        m_have = 0;
        m_retire(m_product);
      end
    end else if (!bus.I_memStall) begin
      if (bus.I_flush) m_bubble();
      else if (bus.I_valid && bus.I_aluMultiCycle) begin
        m_busy = 1; m_waited = 0; m_bubble();
      end else if (bus.I_valid) begin
        m_retire(bus.I_aluResult);
        if (bus.I_setCarry) m_carry = bus.I_aluCout;
      end else m_bubble();
    end
  endtask

  // One clock: check combinational outputs, clock, then check registers
  task automatic cycle();
    logic exp_stall;
    #1;
    if (m_known) begin
      exp_stall = bus.I_memStall || m_busy || (m_have && bus.I_memStall) ||
                  (!m_busy && !m_have && bus.I_valid && bus.I_aluMultiCycle && !bus.I_flush);
      chk("O_stall", bus.O_stall, exp_stall);
      chk("O_Cin", bus.O_Cin, bus.I_useCarry & m_carry);
    end
    last_stall = bus.O_stall;
    @(posedge clk);
    m_update();
    #1;
    chk("O_valid", bus.O_valid, m_valid);
    chk("O_we", bus.O_we, m_we);
    chk("O_carry", bus.O_carry, m_carry);
    chk("O_mulTimeout", bus.O_mulTimeout, m_tmo);
    if (m_valid) begin
      chk("O_result", bus.O_result, m_result);
      chk("O_rd", bus.O_rd, m_rd);
    end
  endtask

  task automatic start_mul(input logic [RD_W-1:0] rd);
    idle();
    bus.I_valid = 1; bus.I_aluMultiCycle = 1; bus.I_rd = rd; bus.I_we = 1;
    bus.I_aluResult = 32'h1234_5678;
  endtask

  initial begin
    int st;
    m_known = 0;
    idle();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    chk("rst_valid", bus.O_valid, 0);
    chk("rst_result", bus.O_result, 0);
    chk("rst_carry", bus.O_carry, 0);

    // add 0xFFFFFFFF + 1 with setCarry, then addc consuming the carry
    idle();
    bus.I_valid = 1; bus.I_aluResult = 32'h0; bus.I_aluCout = 1;
    bus.I_setCarry = 1; bus.I_rd = 5'd3; bus.I_we = 1;
    cycle();
    chk("add_result", bus.O_result, 32'h0);
    chk("add_carry", bus.O_carry, 1);
    chk("add_valid", bus.O_valid, 1);
    idle();
    bus.I_valid = 1; bus.I_useCarry = 1; bus.I_aluResult = 32'd5; bus.I_rd = 5'd4; bus.I_we = 1;
    #1;
    chk("addc_cin", bus.O_Cin, 1);
    cycle();

    // Multiply 7x6: three stall cycles, product the cycle after dataReady
    start_mul(5'd5);
    st = 0;
    cycle(); st += int'(last_stall);
    cycle(); st += int'(last_stall);
    bus.I_aluDataReady = 1; bus.I_aluResult = 32'd42;
    cycle(); st += int'(last_stall);
    chk("mul_result", bus.O_result, 32'd42);
    chk("mul_valid", bus.O_valid, 1);
    chk("mul_carry_kept", bus.O_carry, 1);
    idle();
    cycle(); st += int'(last_stall);
    chk("mul_stall_cycles", st, 3);

    // Multiply with memStall raised for 4 cycles from dataReady onward
    start_mul(5'd9);
    cycle();
    cycle();
    bus.I_aluDataReady = 1; bus.I_aluResult = 32'd42; bus.I_memStall = 1;
    cycle();
    chk("hold_valid", bus.O_valid, 0);
    bus.I_aluDataReady = 0; bus.I_aluResult = 32'hDEAD;
    for (int i = 0; i < 3; i++) cycle();
    chk("hold_valid_still", bus.O_valid, 0);
    bus.I_memStall = 0;
    cycle();
    chk("hold_stall_drop", last_stall, 0);
    chk("hold_result", bus.O_result, 32'd42);
    chk("hold_rd", bus.O_rd, 9);
    chk("hold_valid_out", bus.O_valid, 1);

    // Flush during MUL_WAIT
    start_mul(5'd7);
    cycle();
    bus.I_flush = 1;
    cycle();
    chk("flush_valid", bus.O_valid, 0);
    idle();
    #1;
    chk("flush_stall", bus.O_stall, 0);
    cycle();

    // Product never arrives: watchdog after 7 wait cycles, sticky
    start_mul(5'd2);
    cycle();
    for (int i = 1; i <= 7; i++) begin
      cycle();
      if (i == 6) chk("tmo_early", bus.O_mulTimeout, 0);
    end
    chk("tmo_set", bus.O_mulTimeout, 1);
    bus.I_flush = 1;
    cycle();
    idle();
    for (int i = 0; i < 3; i++) cycle();
    chk("tmo_sticky", bus.O_mulTimeout, 1);

    // Reset in MUL_WAIT
    start_mul(5'd1);
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    idle();
    #1;
    chk("rstmul_stall", bus.O_stall, 0);
    chk("rstmul_valid", bus.O_valid, 0);
    chk("rstmul_tmo", bus.O_mulTimeout, 0);
    chk("rstmul_result", bus.O_result, 0);
    cycle();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.I_valid         = ($urandom_range(0, 3) != 0);
      bus.I_rd            = RD_W'($urandom);
      bus.I_we            = 1'($urandom);
      bus.I_setCarry      = 1'($urandom);
      bus.I_useCarry      = 1'($urandom);
      bus.I_flush         = ($urandom_range(0, 15) == 0);
      bus.I_memStall      = ($urandom_range(0, 3) == 0);
      bus.I_aluResult     = $urandom;
      bus.I_aluCout       = 1'($urandom);
      bus.I_aluMultiCycle = ($urandom_range(0, 3) == 0);
      bus.I_aluDataReady  = ($urandom_range(0, 2) == 0);
      cycle();
    end
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
